// File: rtl/seg7_scan_driver_if.sv
// CPU-side register port and board pin bundle for seg7_scan_driver.
// master: CPU store path / board; slave: the scan driver itself.
interface seg7_scan_driver_if;
    logic        wr_en_i;
    logic        wr_sel_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        frame_o;
    logic [7:0]  led_en_o;
    logic [7:0]  led_c_o;

    modport master (
        output wr_en_i, wr_sel_i, wr_data_i,
        input  rd_data_o, frame_o, led_en_o, led_c_o
    );

    modport slave (
        input  wr_en_i, wr_sel_i, wr_data_i,
        output rd_data_o, frame_o, led_en_o, led_c_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode seven-segment scan driver with double-buffered
// digit/dp registers, programmable dwell and per-dwell dead time.
// Optional build macro SEG7_LZ_BLANK_EN: leading-zero suppression.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      pend_dig;
    logic [7:0]       pend_dp;
    logic [31:0]      shad_dig;
    logic [7:0]       shad_dp;
    logic [7:0]       led_en;
    logic [7:0]       led_c;
    logic             frame;

    logic             dwell_end_c;
    logic             frame_end_c;
    logic             blank_c;
    logic [3:0]       nib_c;
    logic [6:0]       glyph_c;
    logic [6:0]       seg_c;

    assign dwell_end_c = (cnt == CNT_LAST);
    assign frame_end_c = dwell_end_c && (idx == 3'd7);
    assign blank_c     = (cnt < BLANK_END);
    assign nib_c       = shad_dig[{idx, 2'b00} +: 4];

    // Active-low {ca..cg} hex glyphs.
    always_comb begin
        glyph_c = 7'h7F;
        case (nib_c)
            4'h0: glyph_c = 7'b0000001;
            4'h1: glyph_c = 7'b1001111;
            4'h2: glyph_c = 7'b0010010;
            4'h3: glyph_c = 7'b0000110;
            4'h4: glyph_c = 7'b1001100;
            4'h5: glyph_c = 7'b0100100;
            4'h6: glyph_c = 7'b0100000;
            4'h7: glyph_c = 7'b0001111;
            4'h8: glyph_c = 7'b0000000;
            4'h9: glyph_c = 7'b0000100;
            4'hA: glyph_c = 7'b0001000;
            4'hB: glyph_c = 7'b1100000;
            4'hC: glyph_c = 7'b0110001;
            4'hD: glyph_c = 7'b1000010;
            4'hE: glyph_c = 7'b0110000;
            4'hF: glyph_c = 7'b0111000;
            default: glyph_c = 7'h7F;
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [2:0] top_nz_c;

    // Blank segments of digits above the highest nonzero nibble; digit 0 always shows.
    always_comb begin
        top_nz_c = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (shad_dig[4*k +: 4] != 4'h0) begin
                top_nz_c = 3'(k);
            end
        end
        seg_c = (idx > top_nz_c) ? 7'h7F : glyph_c;
    end
`else
    assign seg_c = glyph_c;
`endif

    // Dwell counter and digit index.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= dwell_end_c ? '0 : cnt + CNT_W'(1);
            if (dwell_end_c) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Pending registers, and shadow load at frame end with same-edge write bypass.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pend_dig <= '0;
            pend_dp  <= '0;
            shad_dig <= '0;
            shad_dp  <= '0;
        end else begin
            if (bus.wr_en_i && !bus.wr_sel_i) begin
                pend_dig <= bus.wr_data_i;
            end
            if (bus.wr_en_i && bus.wr_sel_i) begin
                pend_dp <= bus.wr_data_i[7:0];
            end
            if (frame_end_c) begin
                shad_dig <= (bus.wr_en_i && !bus.wr_sel_i) ? bus.wr_data_i : pend_dig;
                shad_dp  <= (bus.wr_en_i && bus.wr_sel_i) ? bus.wr_data_i[7:0] : pend_dp;
            end
        end
    end

    // Registered pin drive and frame pulse.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            led_en <= 8'hFF;
            led_c  <= 8'hFF;
            frame  <= 1'b0;
        end else begin
            frame <= frame_end_c;
            if (blank_c) begin
                led_en <= 8'hFF;
                led_c  <= 8'hFF;
            end else begin
                led_en <= ~(8'd1 << idx);
                led_c  <= {seg_c, ~shad_dp[idx]};
            end
        end
    end

    assign bus.rd_data_o = pend_dig;
    assign bus.frame_o   = frame;
    assign bus.led_en_o  = led_en;
    assign bus.led_c_o   = led_c;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYC=2).
// Reference model derives the display from the absolute cycle position.
module tb_seg7_scan_driver;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 8 * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk  (clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int pos = 0;
    int frames_seen = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_shad = '0;
    logic [7:0]  m_pdp  = '0;
    logic [7:0]  m_sdp  = '0;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        return g[n];
    endfunction

    function automatic logic [7:0] exp_en(input int p);
        int c = p % SD;
        int i = (p / SD) % 8;
        logic [7:0] e = 8'hFF;
        if (c >= BC) e[i] = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] exp_c(input int p, input logic [31:0] d, input logic [7:0] dp);
        int c = p % SD;
        int i = (p / SD) % 8;
        logic [6:0] seg;
        if (c < BC) return 8'hFF;
        seg = glyph(d[4*i +: 4]);
`ifdef SEG7_LZ_BLANK_EN
        begin
            int top = 0;
            for (int k = 0; k < 8; k++) if (d[4*k +: 4] != 4'h0) top = k;
            if (i > top) seg = 7'h7F;
        end
`endif
        return {seg, ~dp[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (pos=%0d)", tag, obs, expv, pos);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check after the edge.
    task automatic cyc(input logic we, input logic sel, input logic [31:0] data);
        logic [7:0] e_en, e_c;
        logic e_fr;
        bus.wr_en_i   = we;
        bus.wr_sel_i  = sel;
        bus.wr_data_i = data;
        e_en = exp_en(pos);
        e_c  = exp_c(pos, m_shad, m_sdp);
        e_fr = ((pos % FRAME) == FRAME - 1);
        @(posedge clk);
        if (we && sel)  m_pdp  = data[7:0];
        if (we && !sel) m_pend = data;
        if (e_fr) begin
            m_shad = m_pend;
            m_sdp  = m_pdp;
        end
        pos++;
        #1;
        bus.wr_en_i = 1'b0;
        check("led_en", 32'(bus.led_en_o), 32'(e_en));
        check("led_c", 32'(bus.led_c_o), 32'(e_c));
        check("frame", 32'(bus.frame_o), 32'(e_fr));
        check("rd_data", bus.rd_data_o, m_pend);
        check("one_digit", 32'($countones(~bus.led_en_o) <= 1), 32'(1));
        if (bus.frame_o) frames_seen++;
    endtask

    task automatic idle_to(input int phase);
        int guard = 0;
        while ((pos % FRAME) != phase && guard < 2 * FRAME) begin
            cyc(1'b0, 1'b0, 32'h0);
            guard++;
        end
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_sel_i  = 1'b0;
        bus.wr_data_i = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_led_en", 32'(bus.led_en_o), 32'hFF);
        check("rst_led_c", 32'(bus.led_c_o), 32'hFF);
        check("rst_frame", 32'(bus.frame_o), 32'h0);
        check("rst_rd", bus.rd_data_o, 32'h0);
        rst = 1'b0;

        // Idle scan: all zeros, one frame pulse in 100 cycles.
        repeat (100) cyc(1'b0, 1'b0, 32'h0);
        check("frames_100", 32'(frames_seen), 32'd1);

        // Mid-frame digit write, visible only after the next frame boundary.
        idle_to(20);
        cyc(1'b1, 1'b0, 32'h0000_81F0);
        repeat (2 * FRAME) cyc(1'b0, 1'b0, 32'h0);

        // dp write on the exact frame-end edge (bypass into the new frame).
        idle_to(FRAME - 1);
        cyc(1'b1, 1'b1, 32'h0000_0001);
        repeat (SD + 2) cyc(1'b0, 1'b0, 32'h0);

        // Asynchronous reset during digit 5.
        idle_to(5 * SD + 4);
        #2 rst = 1'b1;
        #1;
        check("arst_led_en", 32'(bus.led_en_o), 32'hFF);
        check("arst_led_c", 32'(bus.led_c_o), 32'hFF);
        check("arst_frame", 32'(bus.frame_o), 32'h0);
        check("arst_rd", bus.rd_data_o, 32'h0);
        m_pend = '0; m_shad = '0; m_pdp = '0; m_sdp = '0; pos = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (FRAME + 8) cyc(1'b0, 1'b0, 32'h0);

        // Small value (leading-zero suppression case when enabled).
        cyc(1'b1, 1'b0, 32'h0000_0012);
        repeat (2 * FRAME) cyc(1'b0, 1'b0, 32'h0);

        // Randomised writes, including writes landing on frame-end edges.
        for (int n = 0; n < 800; n++) begin
            logic        we  = ($urandom_range(0, 7) == 0) || ((pos % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
            logic        sel = 1'($urandom_range(0, 1));
            logic [31:0] d   = $urandom >> $urandom_range(0, 31);
            cyc(we, sel, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
